// File: rtl/automatic_parity_generator.sv
// -----------------------------------------------------------------------------
// automatic_parity_generator
//
// Purpose:
//   Frames an 8-bit or 14-bit payload with a parity bit and buffers the framed
//   16-bit words in a small FIFO. The FIFO drains towards a downstream parity
//   checker through a valid/ready handshake.
//
//   8-bit frame  : {7'b0, p, in_data[7:0]}   p = XOR(in_data[7:0]) ^ PARITY_ODD
//   16-bit frame : {1'b1, in_data[13:0], p}  p = 1 ^ XOR(in_data) ^ PARITY_ODD
//
//   Optional build macro: PARITY_ERR_INJECT_EN
//     When defined, the input port inject_err is added. It is sampled on input
//     acceptance and inverts the stored parity bit, so that the downstream
//     checker's error path can be exercised.
//
// Parameters:
//   FIFO_DEPTH  number of buffered framed words (power of two, 2..16)
//   PARITY_ODD  0 = even parity, 1 = odd parity
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    payload offered
//   in_ready    payload can be accepted this cycle (FIFO not full)
//   in_mode     0 = 8-bit frame, 1 = 16-bit frame
//   in_data     payload (8-bit mode uses [7:0])
//   inject_err  (PARITY_ERR_INJECT_EN only) invert the stored parity bit
//   data_out    framed word at the FIFO head, 0 when data_valid is low
//   data_valid  FIFO not empty
//   data_ready  downstream consumes data_out
//   word_count  framed words delivered since reset (wraps)
// -----------------------------------------------------------------------------
module automatic_parity_generator #(
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [13:0] in_data,
`ifdef PARITY_ERR_INJECT_EN
  input  logic        inject_err,
`endif
  output logic [15:0] data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic [15:0] word_count
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic        ODD_BIT   = (PARITY_ODD != 0);

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          ready_reg;
  logic [15:0]   word_count_reg;

  logic          push;
  logic          pop;
  logic          full;
  logic          flip;
  logic          p8;
  logic          p16;
  logic [15:0]   frame;

`ifdef PARITY_ERR_INJECT_EN
  assign flip = inject_err;
`else
  assign flip = 1'b0;
`endif

  // Framing is purely combinational so the word is ready for the FIFO write
  // on the same edge that accepts the payload.
  always_comb begin
    p8  = (^in_data[7:0]) ^ ODD_BIT ^ flip;
    p16 = 1'b1 ^ (^in_data) ^ ODD_BIT ^ flip;
    if (in_mode) begin
      frame = {1'b1, in_data, p16};
    end else begin
      frame = {7'b0, p8, in_data[7:0]};
    end
  end

  // ready_reg keeps in_ready low while in reset and rises on the first edge
  // after release. A full FIFO blocks input even if a pop happens this cycle.
  assign full       = (count_reg == DEPTH_CNT);
  assign in_ready   = ready_reg && !full;
  assign data_valid = (count_reg != '0);
  assign push       = in_valid && in_ready;
  assign pop        = data_valid && data_ready;
  assign data_out   = data_valid ? mem[rd_ptr_reg] : 16'h0000;
  assign word_count = word_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_reg      <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      word_count_reg <= 16'h0000;
    end else begin
      ready_reg <= 1'b1;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg     <= rd_ptr_reg + 1'b1;
        word_count_reg <= word_count_reg + 16'd1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: clearing the pointers and occupancy discards
  // whatever words it still holds.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= frame;
    end
  end

endmodule

// File: tb/tb_automatic_parity_generator.sv
// -----------------------------------------------------------------------------
// tb_automatic_parity_generator
//
// Purpose:
//   Self-checking bench for automatic_parity_generator. A recorder pushes the
//   expected framed word into a queue for every accepted payload; a separate
//   monitor pops and compares on every output transfer. Directed scenarios
//   cover reset, framing examples, backpressure, simultaneous push/pop and
//   mid-operation reset; a random phase follows.
// -----------------------------------------------------------------------------
module tb_automatic_parity_generator;

  localparam int DEPTH = 4;
  localparam int ODD   = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_mode = 1'b0;
  logic [13:0] in_data = '0;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_ready = 1'b0;
  logic [15:0] word_count;
`ifdef PARITY_ERR_INJECT_EN
  logic        inject_err = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int accepts = 0;
  int pops = 0;
  logic [15:0] exp_q[$];

  automatic_parity_generator #(
    .FIFO_DEPTH(DEPTH),
    .PARITY_ODD(ODD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
`ifdef PARITY_ERR_INJECT_EN
    .inject_err(inject_err),
`endif
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Reference framing: choose the parity bit so the frame meets the rule,
  // using population counts rather than any XOR tree.
  function automatic logic [15:0] ref_frame(input logic mode, input logic [13:0] d);
    logic [15:0] w;
    if (!mode) begin
      w = {8'h00, d[7:0]};
      if (($countones(d[7:0]) % 2) != ODD) w[8] = 1'b1;
    end else begin
      w = {1'b1, d, 1'b0};
      if (($countones(w) % 2) != ODD) w[0] = 1'b1;
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Recorder: a handshake seen at the negedge completes at the next posedge.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back(ref_frame(in_mode, in_data));
      accepts++;
    end
  end

  // Monitor: compares every output transfer against the scoreboard head.
  logic        prev_hold = 1'b0;
  logic [15:0] prev_out  = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", data_out, 16'hxxxx);
        end else begin
          chk("out_word", data_out, exp_q.pop_front());
        end
        pops++;
        $display("out word=%h count_before=%0d", data_out, word_count);
      end
      if (!data_valid) chk("idle_zero", data_out, 16'h0000);
      if (prev_hold && data_valid) chk("hold_stable", data_out, prev_out);
      prev_hold = data_valid && !data_ready;
      prev_out  = data_out;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one payload and wait (bounded) until it is accepted.
  task automatic send(input logic m, input logic [13:0] d);
    bit got = 0;
    in_mode  = m;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("send_timeout", 16'd0, 16'd1);
    tick();
    in_valid = 1'b0;
    $display("in mode=%0d data=%h", m, d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    pops = 0;
    accepts = 0;
    #1;
    chk("rst_valid", {15'd0, data_valid}, 16'd0);
    chk("rst_out", data_out, 16'h0000);
    chk("rst_count", word_count, 16'h0000);
    chk("rst_ready", {15'd0, in_ready}, 16'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #2;
    chk("ready_before_edge", {15'd0, in_ready}, 16'd0);
    tick();
    chk("ready_after_release", {15'd0, in_ready}, 16'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [13:0] words [5];
    #1;
    do_reset();

    // Framing examples.
    data_ready = 1'b1;
    send(1'b0, 14'h0055);
    chk("frame8_55", data_out, 16'h0055);
    send(1'b0, 14'h0007);
    chk("frame8_07", data_out, 16'h0107);
    send(1'b1, 14'h0091);
    chk("frame16_91", data_out, 16'h8122);
    chk("frame16_xor", {15'd0, ^data_out}, 16'(ODD));
    tick();
    tick();

    // Backpressure: four accepted back-to-back, fifth held off.
    do_reset();
    data_ready = 1'b0;
    for (int k = 0; k < 5; k++) words[k] = 14'(k * 14'h0123 + 14'h0011);
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_mode = k[0];
      in_data = words[k];
      tick();
    end
    chk("bp_full_ready", {15'd0, in_ready}, 16'd0);
    in_data = words[4];
    for (int k = 0; k < 3; k++) tick();
    chk("bp_held_ready", {15'd0, in_ready}, 16'd0);
    chk("bp_accepts", 16'(accepts), 16'd4);
    in_valid = 1'b0;
    data_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("bp_word_count", word_count, 16'd4);
    chk("bp_drained", {15'd0, data_valid}, 16'd0);

    // Simultaneous push and pop with two words buffered.
    data_ready = 1'b0;
    send(1'b0, 14'h00A5);
    send(1'b1, 14'h1234);
    data_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_mode = 1'($urandom);
      in_data = 14'($urandom);
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!data_valid) break;
      n++;
      tick();
    end
    chk("pushpop_occupancy", 16'(n), 16'd2);

    // Reset with three words buffered: nothing stale afterwards.
    data_ready = 1'b0;
    send(1'b0, 14'h0001);
    send(1'b0, 14'h0002);
    send(1'b1, 14'h0003);
    #3;
    do_reset();
    data_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    chk("post_rst_valid", {15'd0, data_valid}, 16'd0);
    chk("post_rst_count", word_count, 16'd0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      in_valid   = 1'($urandom);
      data_ready = ($urandom_range(0, 3) != 0);
      in_mode    = 1'($urandom);
      in_data    = 14'($urandom);
      tick();
    end
    in_valid = 1'b0;
    data_ready = 1'b1;
    for (int k = 0; k < DEPTH + 4; k++) tick();
    chk("rand_drained", 16'(exp_q.size()), 16'd0);
    chk("rand_word_count", word_count, 16'(pops));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
